// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing with stall-deferred branch redirect,
// synchronous-SRAM fetch port, and a stall-stable instruction hold buffer for decode.
package if_fetch_pkg;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned STALL_W     = 3;
  localparam int unsigned BR_WD       = 1 + ADDR_W;
  localparam int unsigned IF_TO_ID_WD = 1 + ADDR_W;
  localparam logic        STOP        = 1'b1;

  typedef struct packed {
    logic              br_e;
    logic [ADDR_W-1:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic              ce;
    logic [ADDR_W-1:0] pc;
  } if_to_id_t;
endpackage

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  input  logic [INST_W-1:0]      inst_sram_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [ADDR_W-1:0]      inst_sram_addr,
  output logic [INST_W-1:0]      inst_sram_wdata,
  output logic [INST_W-1:0]      id_inst,
  output logic                   fetch_adel
);

  logic [ADDR_W-1:0] pc_reg;
  logic              ce_reg;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_addr;
  logic              hold_valid;
  logic [INST_W-1:0] hold_inst;

  br_bus_t           br;
  if_to_id_t         fd;
  logic [ADDR_W-1:0] next_pc;
  logic              pc_stall;
  logic              id_stall;
  logic              bubble;

  assign br       = br_bus_t'(br_bus);
  assign pc_stall = (stall[0] == STOP);
  assign id_stall = (stall[2] == STOP);
  assign bubble   = (stall[1] == STOP) && !id_stall;

  // A live branch beats a redirect deferred from an earlier stalled cycle.
  always_comb begin
    next_pc = pc_reg + ADDR_W'(4);
    if (br.br_e)
      next_pc = br.br_addr;
    else if (redir_pend)
      next_pc = redir_addr;
  end

  // PC, fetch enable and deferred redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      ce_reg     <= 1'b0;
      redir_pend <= 1'b0;
      redir_addr <= '0;
    end else if (!pc_stall) begin
      pc_reg     <= next_pc;
      ce_reg     <= 1'b1;
      redir_pend <= 1'b0;
    end else if (br.br_e) begin
      redir_pend <= 1'b1;
      redir_addr <= br.br_addr;
    end
  end

  // Capture the SRAM word on the first ID-stall cycle so decode sees a stable word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= '0;
    end else if (id_stall) begin
      if (!hold_valid) begin
        hold_inst  <= inst_sram_rdata;
        hold_valid <= 1'b1;
      end
    end else if (bubble || !id_stall) begin
      hold_valid <= 1'b0;
    end
  end

  assign fetch_adel      = ce_reg & (pc_reg[1:0] != 2'b00);
  assign inst_sram_en    = ce_reg & ~fetch_adel;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = '0;

  assign fd.ce        = ce_reg;
  assign fd.pc        = pc_reg;
  assign if_to_id_bus = IF_TO_ID_WD'(fd);

  assign id_inst = hold_valid ? hold_inst : inst_sram_rdata;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model of the fetch stage.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stall;
  logic [32:0] br_bus;
  logic [31:0] rdata;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] id_inst;
  logic        fetch_adel;

  int checks   = 0;
  int failures = 0;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .inst_sram_rdata(rdata), .if_to_id_bus(if_to_id_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .id_inst(id_inst), .fetch_adel(fetch_adel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 3'b000; br_bus = '0; rdata = 32'h0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 3'b111; br_bus = {1'b1, 32'h1234_5678}; rdata = 32'hDEAD_BEEF;
    step(); step();
    #1;
    checks++;
    if (if_to_id_bus !== {1'b0, RST_PC}) begin
      failures++; $display("FAIL reset_bus got %h exp %h", if_to_id_bus, {1'b0, RST_PC});
    end
    checks++;
    if (inst_sram_en !== 1'b0 || fetch_adel !== 1'b0) begin
      failures++; $display("FAIL reset_en_adel got %b%b exp 00", inst_sram_en, fetch_adel);
    end
    checks++;
    if (id_inst !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL reset_id_inst got %h exp deadbeef", id_inst);
    end
    checks++;
    if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin
      failures++; $display("FAIL reset_wen_wdata got %h %h exp 0 0", inst_sram_wen, inst_sram_wdata);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hBFC0_0000; exp_addr[1] = 32'hBFC0_0004; exp_addr[2] = 32'hBFC0_0008;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_sram_addr !== exp_addr[i] || inst_sram_en !== 1'b1 || if_to_id_bus[32] !== 1'b1) begin
        failures++;
        $display("FAIL seq_addr%0d got addr=%h en=%b ce=%b exp addr=%h en=1 ce=1",
                 i, inst_sram_addr, inst_sram_en, if_to_id_bus[32], exp_addr[i]);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    br_bus = {1'b1, 32'h8000_1000};
    step();
    br_bus = '0;
    checks++;
    if (inst_sram_addr !== 32'h8000_1000) begin
      failures++; $display("FAIL branch_target got %h exp 80001000", inst_sram_addr);
    end
    step();
    checks++;
    if (inst_sram_addr !== 32'h8000_1004) begin
      failures++; $display("FAIL branch_next got %h exp 80001004", inst_sram_addr);
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    step();
    for (int c = 0; c < 3; c++) begin
      stall  = 3'b001;
      br_bus = (c == 1) ? {1'b1, 32'h8000_2000} : 33'h0;
      step();
      checks++;
      if (inst_sram_addr !== 32'hBFC0_0000) begin
        failures++; $display("FAIL stall_hold%0d got %h exp bfc00000", c, inst_sram_addr);
      end
    end
    stall = 3'b000; br_bus = '0;
    step();
    checks++;
    if (inst_sram_addr !== 32'h8000_2000) begin
      failures++; $display("FAIL stall_redirect got %h exp 80002000", inst_sram_addr);
    end
    step();
    checks++;
    if (inst_sram_addr !== 32'h8000_2004) begin
      failures++; $display("FAIL redirect_cleared got %h exp 80002004", inst_sram_addr);
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(); step();
    stall = 3'b100; rdata = 32'h3C01_1234;
    #1;
    checks++;
    if (id_inst !== 32'h3C01_1234) begin
      failures++; $display("FAIL hold_onset got %h exp 3c011234", id_inst);
    end
    for (int c = 1; c < 4; c++) begin
      step();
      rdata = $urandom | 32'h1;
      #1;
      checks++;
      if (id_inst !== 32'h3C01_1234) begin
        failures++; $display("FAIL hold_cycle%0d got %h exp 3c011234", c, id_inst);
      end
    end
    step();
    stall = 3'b000;
    step();
    rdata = 32'hA5A5_0F0F;
    #1;
    checks++;
    if (id_inst !== 32'hA5A5_0F0F) begin
      failures++; $display("FAIL hold_release got %h exp a5a50f0f", id_inst);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    step();
    br_bus = {1'b1, 32'h8000_0002};
    step();
    br_bus = '0;
    checks++;
    if (fetch_adel !== 1'b1 || inst_sram_en !== 1'b0 || if_to_id_bus !== {1'b1, 32'h8000_0002}) begin
      failures++;
      $display("FAIL misalign got adel=%b en=%b bus=%h exp adel=1 en=0 bus=180000002",
               fetch_adel, inst_sram_en, if_to_id_bus);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    stall = 3'b101; br_bus = {1'b1, 32'h8000_3000}; rdata = 32'h1111_2222;
    step();
    br_bus = '0; rst = 1'b1;
    step();
    checks++;
    if (if_to_id_bus !== {1'b0, RST_PC}) begin
      failures++; $display("FAIL midreset_bus got %h exp %h", if_to_id_bus, {1'b0, RST_PC});
    end
    rst = 1'b0; stall = 3'b000; rdata = 32'h3333_4444;
    #1;
    checks++;
    if (id_inst !== 32'h3333_4444) begin
      failures++; $display("FAIL midreset_hold got %h exp 33334444", id_inst);
    end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0000) begin
      failures++; $display("FAIL midreset_fetch got %h exp bfc00000", inst_sram_addr);
    end
  endtask

  // Model: PC + fetch-valid, latest deferred target in a queue, word captured at ID-stall onset.
  task automatic test_random();
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] pend_q [$];
    logic        m_hv;
    logic [31:0] m_hold;
    logic        e_adel;
    logic [31:0] tgt;
    do_reset();
    m_pc = RST_PC; m_ce = 1'b0; m_hv = 1'b0; m_hold = '0;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) < 3);
      stall = 3'($urandom_range(0, 7) & (($urandom_range(0, 1) != 0) ? 7 : 0));
      tgt   = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      br_bus = {($urandom_range(0, 4) == 0), tgt};
      rdata  = $urandom;
      #1;
      e_adel = m_ce && (m_pc[1:0] != 2'b00);
      checks++;
      if (if_to_id_bus !== {m_ce, m_pc} || inst_sram_en !== (m_ce && !e_adel) || fetch_adel !== e_adel) begin
        failures++;
        $display("FAIL rand_fetch%0d got bus=%h en=%b adel=%b exp bus=%h en=%b adel=%b",
                 n, if_to_id_bus, inst_sram_en, fetch_adel, {m_ce, m_pc}, m_ce && !e_adel, e_adel);
      end
      checks++;
      if (id_inst !== (m_hv ? m_hold : rdata)) begin
        failures++;
        $display("FAIL rand_id_inst%0d got %h exp %h", n, id_inst, m_hv ? m_hold : rdata);
      end
      if (rst) begin
        m_pc = RST_PC; m_ce = 1'b0; pend_q.delete(); m_hv = 1'b0; m_hold = '0;
      end else begin
        if (!stall[0]) begin
          if (br_bus[32])            m_pc = br_bus[31:0];
          else if (pend_q.size() > 0) m_pc = pend_q[$];
          else                       m_pc = m_pc + 32'd4;
          m_ce = 1'b1;
          pend_q.delete();
        end else if (br_bus[32]) begin
          pend_q.push_back(br_bus[31:0]);
        end
        if (stall[2]) begin
          if (!m_hv) begin m_hv = 1'b1; m_hold = rdata; end
        end else begin
          m_hv = 1'b0;
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = '0; br_bus = '0; rdata = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_hold();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
